// File: rtl/d_latch_pkg.sv
// Shared definitions for the d_latch_bank block.
//   mode_e       : operating mode encoding carried on the 2-bit mode port
//   snap_state_e : snapshot FSM state encoding
package d_latch_pkg;

  typedef enum logic [1:0] {
    MODE_TRANSPARENT = 2'b00,
    MODE_EDGE        = 2'b01,
    MODE_SNAPSHOT    = 2'b10,
    MODE_HOLD        = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SNAP_IDLE    = 2'b00,
    SNAP_CAPTURE = 2'b01,
    SNAP_DONE    = 2'b10
  } snap_state_e;

endpackage

// File: rtl/d_latch_cell.sv
// One storage channel: WIDTH-bit register with load strobe and a sticky
// change flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : write d into q this cycle
//   clr      : clear the sticky change flag (a same-cycle set wins)
//   d, q     : channel data in / registered out
//   chg      : sticky flag, set when a load actually alters q
module d_latch_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             chg
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      chg <= 1'b0;
    end else begin
      if (load) q <= d;
      // Rewriting an identical value is not a change.
      if (load && (d != q)) chg <= 1'b1;
      else if (clr)         chg <= 1'b0;
    end
  end

endmodule

// File: rtl/d_latch_bank.sv
// Bank of CHANNELS independent WIDTH-bit storage channels with four modes:
// transparent (level enable), edge (rising enable), snapshot (all channels
// through a 3-state FSM) and hold (everything frozen).
//   clk, rst   : clock, synchronous active-high reset
//   mode       : 00 transparent, 01 edge, 10 snapshot, 11 hold
//   en         : per-channel enable (unused in snapshot/hold)
//   d, q       : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   snap_req   : start a snapshot (mode 10, FSM idle)
//   snap_ack   : consumer acknowledge, releases snap_done
//   chg_clr    : per-channel clear of the sticky change flag
//   chg        : per-channel sticky change flag
//   snap_busy  : snapshot FSM not idle
//   snap_done  : snapshot captured, waiting for ack
module d_latch_bank
  import d_latch_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      snap_req,
  input  logic                      snap_ack,
  input  logic [CHANNELS-1:0]       chg_clr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       chg,
  output logic                      snap_busy,
  output logic                      snap_done
);

  mode_e               mode_i;
  snap_state_e         state, state_n;
  logic [CHANNELS-1:0] en_prev;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] clr;
  logic                capture;

  assign mode_i = mode_e'(mode);

  // en_prev tracks every cycle regardless of mode so an edge seen in
  // another mode is never replayed when EDGE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_prev <= '0;
      state   <= SNAP_IDLE;
    end else begin
      en_prev <= en;
      state   <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    // Leaving snapshot mode mid-transaction aborts it, HOLD included.
    if (state != SNAP_IDLE && mode_i != MODE_SNAPSHOT) begin
      state_n = SNAP_IDLE;
    end else begin
      case (state)
        SNAP_IDLE:    if (snap_req && mode_i == MODE_SNAPSHOT) state_n = SNAP_CAPTURE;
        SNAP_CAPTURE: begin
          capture = 1'b1;
          state_n = SNAP_DONE;
        end
        SNAP_DONE:    if (snap_ack) state_n = SNAP_IDLE;
        default:      state_n = SNAP_IDLE;
      endcase
    end
  end

  always_comb begin
    load = '0;
    case (mode_i)
      MODE_TRANSPARENT: load = en;
      MODE_EDGE:        load = en & ~en_prev;
      MODE_SNAPSHOT:    load = {CHANNELS{capture}};
      default:          load = '0;
    endcase
  end

  // HOLD freezes the change flags too.
  assign clr = (mode_i == MODE_HOLD) ? '0 : chg_clr;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_cell
      d_latch_cell #(.WIDTH(WIDTH)) u_cell (
        .clk  (clk),
        .rst  (rst),
        .load (load[k]),
        .clr  (clr[k]),
        .d    (d[k*WIDTH +: WIDTH]),
        .q    (q[k*WIDTH +: WIDTH]),
        .chg  (chg[k])
      );
    end
  endgenerate

  assign snap_busy = (state != SNAP_IDLE);
  assign snap_done = (state == SNAP_DONE);

endmodule
